// File: rtl/tomasulo_pkg.sv
// Shared types for the aged reservation station: entry, dispatch, issue and CDB records.
// Field widths are fixed here. The top-level parameters default to these values.
package tomasulo_pkg;

  localparam int RS_TAG_W  = 4;
  localparam int RS_DATA_W = 32;
  localparam int RS_OP_W   = 4;

  typedef struct packed {
    logic                 rdy;
    logic [RS_TAG_W-1:0]  tag;
    logic [RS_DATA_W-1:0] data;
  } rs_src_t;

  typedef struct packed {
    logic                valid;
    logic [RS_OP_W-1:0]  op;
    logic [RS_TAG_W-1:0] dst_tag;
    rs_src_t             s0;
    rs_src_t             s1;
  } rs_entry_t;

  typedef struct packed {
    logic                vld;
    logic [RS_OP_W-1:0]  op;
    logic [RS_TAG_W-1:0] dst_tag;
    rs_src_t             s0;
    rs_src_t             s1;
  } rs_dis_t;

  typedef struct packed {
    logic [RS_OP_W-1:0]   op;
    logic [RS_TAG_W-1:0]  dst_tag;
    logic [RS_DATA_W-1:0] s0;
    logic [RS_DATA_W-1:0] s1;
  } rs_iss_t;

  typedef struct packed {
    logic                 vld;
    logic [RS_TAG_W-1:0]  tag;
    logic [RS_DATA_W-1:0] data;
  } rs_cdb_t;

  // A waiting source picks up a matching broadcast; sources that are already ready are untouched.
  function automatic rs_src_t snoop_src(input rs_src_t s, input rs_cdb_t cdb);
    rs_src_t r;
    r = s;
    if (!s.rdy && cdb.vld && (s.tag == cdb.tag)) begin
      r.rdy  = 1'b1;
      r.data = cdb.data;
    end
    return r;
  endfunction

endpackage

// File: rtl/tomasulo_age_matrix.sv
// Relative-age matrix: older_q[i][j] is set when entry i was allocated before entry j.
// The output is the one-hot oldest requester.
module tomasulo_age_matrix #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] alloc_i,
  input  logic [N-1:0] free_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] oldest_o,
  output logic         any_o
);

  logic [N-1:0] older_q [N];

  // A new entry is younger than everything, so its row clears and its column sets.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (free_i[i] || alloc_i[i] || free_i[j]) begin
            older_q[i][j] <= 1'b0;
          end else if (alloc_i[j] && (i != j)) begin
            older_q[i][j] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    oldest_o = '0;
    for (int i = 0; i < N; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (req_i[j] && older_q[j][i]) blocked = 1'b1;
      end
      oldest_o[i] = req_i[i] && !blocked;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/tomasulo_rs_aged.sv
// Reservation station with CDB snooping and oldest-ready issue into a registered output stage.
// Handshake: dispatch fires on dis_vld && dis_rdy; issue advances when !iss_vld_r || iss_rdy.
module tomasulo_rs_aged
  import tomasulo_pkg::*;
#(
  parameter int N      = 4,
  parameter int TAG_W  = RS_TAG_W,
  parameter int DATA_W = RS_DATA_W,
  parameter int OP_W   = RS_OP_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dis_vld,
  output logic                   dis_rdy,
  input  logic [OP_W-1:0]        dis_op,
  input  logic [TAG_W-1:0]       dis_dst_tag,
  input  logic                   dis_s0_rdy,
  input  logic [TAG_W-1:0]       dis_s0_tag,
  input  logic [DATA_W-1:0]      dis_s0_data,
  input  logic                   dis_s1_rdy,
  input  logic [TAG_W-1:0]       dis_s1_tag,
  input  logic [DATA_W-1:0]      dis_s1_data,
  input  logic                   cdb_vld,
  input  logic [TAG_W-1:0]       cdb_tag,
  input  logic [DATA_W-1:0]      cdb_data,
  output logic                   iss_vld_r,
  input  logic                   iss_rdy,
  output logic [OP_W-1:0]        iss_op_r,
  output logic [TAG_W-1:0]       iss_dst_tag_r,
  output logic [DATA_W-1:0]      iss_s0_r,
  output logic [DATA_W-1:0]      iss_s1_r,
  output logic                   full_r,
  output logic                   empty_r,
  output logic [$clog2(N+1)-1:0] occ_r
);

  localparam int OCC_W = $clog2(N+1);

  rs_entry_t        ent_q [N];
  rs_entry_t        ent_d [N];
  rs_iss_t          iss_q;
  logic             iss_vld_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             full_q, empty_q;

  rs_cdb_t   cdb;
  rs_dis_t   dis;
  rs_entry_t sel_ent;
  logic [N-1:0] valid_vec, ready_vec, free_slot_oh, alloc_oh, free_oh, sel_oh;
  logic sel_any, dis_fire, load, iss_fire;

  assign cdb = '{vld: cdb_vld, tag: cdb_tag, data: cdb_data};

  always_comb begin
    dis.vld     = dis_vld;
    dis.op      = dis_op;
    dis.dst_tag = dis_dst_tag;
    dis.s0      = snoop_src('{rdy: dis_s0_rdy, tag: dis_s0_tag, data: dis_s0_data}, cdb);
    dis.s1      = snoop_src('{rdy: dis_s1_rdy, tag: dis_s1_tag, data: dis_s1_data}, cdb);
  end

  // Ready uses registered source state only, so a wakeup issues no earlier than the next cycle.
  always_comb begin
    logic found;
    found        = 1'b0;
    free_slot_oh = '0;
    for (int i = 0; i < N; i++) begin
      valid_vec[i] = ent_q[i].valid;
      ready_vec[i] = ent_q[i].valid && ent_q[i].s0.rdy && ent_q[i].s1.rdy;
      if (!ent_q[i].valid && !found) begin
        free_slot_oh[i] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  assign dis_rdy  = !full_q;
  assign dis_fire = dis.vld && !full_q;
  assign alloc_oh = dis_fire ? free_slot_oh : '0;
  assign load     = !iss_vld_q || iss_rdy;
  assign iss_fire = load && sel_any;
  assign free_oh  = iss_fire ? sel_oh : '0;

  tomasulo_age_matrix #(.N(N)) u_age (
    .clk      (clk),
    .rst      (rst),
    .alloc_i  (alloc_oh),
    .free_i   (free_oh),
    .req_i    (ready_vec),
    .oldest_o (sel_oh),
    .any_o    (sel_any)
  );

  always_comb begin
    sel_ent = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_oh[i]) sel_ent = ent_q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ent_d[i] = ent_q[i];
      if (valid_vec[i]) begin
        ent_d[i].s0 = snoop_src(ent_q[i].s0, cdb);
        ent_d[i].s1 = snoop_src(ent_q[i].s1, cdb);
      end
      if (free_oh[i]) ent_d[i].valid = 1'b0;
      if (alloc_oh[i]) begin
        ent_d[i] = '{valid: 1'b1, op: dis.op, dst_tag: dis.dst_tag, s0: dis.s0, s1: dis.s1};
      end
    end
  end

  // Only valid bits are reset; payload fields are don't-care until allocated.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) ent_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) ent_q[i] <= ent_d[i];
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({dis_fire, iss_fire})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_vld_q <= 1'b0;
      occ_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      if (load) iss_vld_q <= sel_any;
      occ_q   <= occ_d;
      full_q  <= (occ_d == OCC_W'(N));
      empty_q <= (occ_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (iss_fire) begin
      iss_q <= '{op: sel_ent.op, dst_tag: sel_ent.dst_tag, s0: sel_ent.s0.data, s1: sel_ent.s1.data};
    end
  end

  assign iss_vld_r     = iss_vld_q;
  assign iss_op_r      = iss_q.op;
  assign iss_dst_tag_r = iss_q.dst_tag;
  assign iss_s0_r      = iss_q.s0;
  assign iss_s1_r      = iss_q.s1;
  assign full_r        = full_q;
  assign empty_r       = empty_q;
  assign occ_r         = occ_q;

endmodule

// File: tb/tb_tomasulo_rs_aged.sv
// Directed bench for tomasulo_rs_aged (N=4): per-cycle vector table plus a back-to-back issue sequence.
module tb_tomasulo_rs_aged;

  localparam int N      = 4;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int OCC_W  = $clog2(N+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              dis_vld, dis_rdy;
  logic [OP_W-1:0]   dis_op;
  logic [TAG_W-1:0]  dis_dst_tag;
  logic              dis_s0_rdy, dis_s1_rdy;
  logic [TAG_W-1:0]  dis_s0_tag, dis_s1_tag;
  logic [DATA_W-1:0] dis_s0_data, dis_s1_data;
  logic              cdb_vld;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              iss_vld_r, iss_rdy;
  logic [OP_W-1:0]   iss_op_r;
  logic [TAG_W-1:0]  iss_dst_tag_r;
  logic [DATA_W-1:0] iss_s0_r, iss_s1_r;
  logic              full_r, empty_r;
  logic [OCC_W-1:0]  occ_r;

  tomasulo_rs_aged #(.N(N), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst),
    .dis_vld(dis_vld), .dis_rdy(dis_rdy), .dis_op(dis_op), .dis_dst_tag(dis_dst_tag),
    .dis_s0_rdy(dis_s0_rdy), .dis_s0_tag(dis_s0_tag), .dis_s0_data(dis_s0_data),
    .dis_s1_rdy(dis_s1_rdy), .dis_s1_tag(dis_s1_tag), .dis_s1_data(dis_s1_data),
    .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_vld_r(iss_vld_r), .iss_rdy(iss_rdy), .iss_op_r(iss_op_r),
    .iss_dst_tag_r(iss_dst_tag_r), .iss_s0_r(iss_s0_r), .iss_s1_r(iss_s1_r),
    .full_r(full_r), .empty_r(empty_r), .occ_r(occ_r)
  );

  typedef struct {
    logic              rst;
    logic              dv;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dst;
    logic              s0r;
    logic [TAG_W-1:0]  s0t;
    logic [DATA_W-1:0] s0d;
    logic              s1r;
    logic [TAG_W-1:0]  s1t;
    logic [DATA_W-1:0] s1d;
    logic              cv;
    logic [TAG_W-1:0]  ct;
    logic [DATA_W-1:0] cd;
    logic              ir;
    logic              ev;
    logic [OP_W-1:0]   eop;
    logic [TAG_W-1:0]  edst;
    logic [DATA_W-1:0] es0;
    logic [DATA_W-1:0] es1;
    logic [OCC_W-1:0]  eocc;
  } vec_t;

  vec_t vq[$];
  logic [TAG_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t v(int rst_, int dv, int op, int dst, int s0r, int s0t, int s0d,
                             int s1r, int s1t, int s1d, int cv, int ct, int cd, int ir,
                             int ev, int eop, int edst, int es0, int es1, int eocc);
    vec_t x;
    x.rst = rst_[0];  x.dv = dv[0];  x.op = OP_W'(op);  x.dst = TAG_W'(dst);
    x.s0r = s0r[0];   x.s0t = TAG_W'(s0t);  x.s0d = DATA_W'(s0d);
    x.s1r = s1r[0];   x.s1t = TAG_W'(s1t);  x.s1d = DATA_W'(s1d);
    x.cv = cv[0];     x.ct = TAG_W'(ct);    x.cd = DATA_W'(cd);  x.ir = ir[0];
    x.ev = ev[0];     x.eop = OP_W'(eop);   x.edst = TAG_W'(edst);
    x.es0 = DATA_W'(es0);  x.es1 = DATA_W'(es1);  x.eocc = OCC_W'(eocc);
    return x;
  endfunction

  task automatic drive(input vec_t x);
    rst = x.rst;  dis_vld = x.dv;  dis_op = x.op;  dis_dst_tag = x.dst;
    dis_s0_rdy = x.s0r;  dis_s0_tag = x.s0t;  dis_s0_data = x.s0d;
    dis_s1_rdy = x.s1r;  dis_s1_tag = x.s1t;  dis_s1_data = x.s1d;
    cdb_vld = x.cv;  cdb_tag = x.ct;  cdb_data = x.cd;  iss_rdy = x.ir;
  endtask

  task automatic check(input int idx, input vec_t x);
    logic e_full;
    e_full = (x.eocc == OCC_W'(N));
    n_vec++;
    if (iss_vld_r !== x.ev) begin
      n_bad++; $display("FAIL v%0d iss_vld_r got %b want %b", idx, iss_vld_r, x.ev);
    end
    if (occ_r !== x.eocc) begin
      n_bad++; $display("FAIL v%0d occ_r got %0d want %0d", idx, occ_r, x.eocc);
    end
    if (full_r !== e_full || dis_rdy !== !e_full) begin
      n_bad++; $display("FAIL v%0d full_r/dis_rdy got %b/%b want %b/%b", idx, full_r, dis_rdy, e_full, !e_full);
    end
    if (empty_r !== (x.eocc == '0)) begin
      n_bad++; $display("FAIL v%0d empty_r got %b want %b", idx, empty_r, (x.eocc == '0));
    end
    if (x.ev) begin
      if (iss_op_r !== x.eop || iss_dst_tag_r !== x.edst) begin
        n_bad++; $display("FAIL v%0d op/dst got %h/%h want %h/%h", idx, iss_op_r, iss_dst_tag_r, x.eop, x.edst);
      end
      if (iss_s0_r !== x.es0 || iss_s1_r !== x.es1) begin
        n_bad++; $display("FAIL v%0d s0/s1 got %h/%h want %h/%h", idx, iss_s0_r, iss_s1_r, x.es0, x.es1);
      end
    end
  endtask

  initial begin
    int first_c, last_c;
    //        rst dv op dst s0r s0t s0d   s1r s1t s1d   cv ct cd    ir   ev eop edst es0   es1   occ
    vq.push_back(v(1, 0, 0, 0,  0, 0, 0,     0, 0, 0,     0, 0, 0,    0,   0, 0, 0,  0,    0,    0));
    // single ready dispatch, two-cycle latency
    vq.push_back(v(0, 1, 1, 3,  1, 0, 'h10,  1, 0, 'h20,  0, 0, 0,    1,   0, 0, 0,  0,    0,    1));
    vq.push_back(v(0, 0, 0, 0,  0, 0, 0,     0, 0, 0,     0, 0, 0,    1,   1, 1, 3,  'h10, 'h20, 0));
    vq.push_back(v(0, 0, 0, 0,  0, 0, 0,     0, 0, 0,     0, 0, 0,    1,   0, 0, 0,  0,    0,    0));
    // A waits on tag 5, B ready; B issues first, A then with the CDB value
    vq.push_back(v(0, 1, 2, 4,  0, 5, 0,     1, 0, 'h01,  0, 0, 0,    1,   0, 0, 0,  0,    0,    1));
    vq.push_back(v(0, 1, 3, 6,  1, 0, 'h02,  1, 0, 'h03,  0, 0, 0,    1,   0, 0, 0,  0,    0,    2));
    vq.push_back(v(0, 0, 0, 0,  0, 0, 0,     0, 0, 0,     1, 5, 'hAA, 1,   1, 3, 6,  'h02, 'h03, 1));
    vq.push_back(v(0, 0, 0, 0,  0, 0, 0,     0, 0, 0,     0, 0, 0,    1,   1, 2, 4,  'hAA, 'h01, 0));
    vq.push_back(v(0, 0, 0, 0,  0, 0, 0,     0, 0, 0,     0, 0, 0,    1,   0, 0, 0,  0,    0,    0));
    // dispatch-cycle CDB bypass on s1
    vq.push_back(v(0, 1, 4, 7,  1, 0, 'h30,  0, 7, 0,     1, 7, 'h55, 1,   0, 0, 0,  0,    0,    1));
    vq.push_back(v(0, 0, 0, 0,  0, 0, 0,     0, 0, 0,     0, 0, 0,    1,   1, 4, 7,  'h30, 'h55, 0));
    vq.push_back(v(0, 0, 0, 0,  0, 0, 0,     0, 0, 0,     0, 0, 0,    1,   0, 0, 0,  0,    0,    0));
    // fill with four entries waiting on tag 9
    for (int k = 0; k < 4; k++)
      vq.push_back(v(0, 1, 5+k, 8+k, 0, 9, 0, 1, 0, 'h40+k, 0, 0, 0,  1,   0, 0, 0,  0,    0,    k+1));
    // full: 5th dispatch held, unmatched CDB ignored, then tag 9 wakes all four
    vq.push_back(v(0, 1, 9, 12, 1, 0, 'h50,  1, 0, 'h51,  1, 2, 'hEE, 1,   0, 0, 0,  0,    0,    4));
    vq.push_back(v(0, 1, 9, 12, 1, 0, 'h50,  1, 0, 'h51,  1, 9, 'h99, 0,   0, 0, 0,  0,    0,    4));
    vq.push_back(v(0, 1, 9, 12, 1, 0, 'h50,  1, 0, 'h51,  0, 0, 0,    1,   1, 5, 8,  'h99, 'h40, 3));
    // freed slot 0 takes the held dispatch while the output stalls for five cycles
    vq.push_back(v(0, 1, 9, 12, 1, 0, 'h50,  1, 0, 'h51,  0, 0, 0,    0,   1, 5, 8,  'h99, 'h40, 4));
    for (int k = 0; k < 4; k++)
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0,    0,   1, 5, 8,  'h99, 'h40, 4));
    // drain by age: slot 0 holds the youngest entry and goes last
    vq.push_back(v(0, 0, 0, 0,  0, 0, 0,     0, 0, 0,     0, 0, 0,    1,   1, 6, 9,  'h99, 'h41, 3));
    vq.push_back(v(0, 0, 0, 0,  0, 0, 0,     0, 0, 0,     0, 0, 0,    1,   1, 7, 10, 'h99, 'h42, 2));
    vq.push_back(v(0, 0, 0, 0,  0, 0, 0,     0, 0, 0,     0, 0, 0,    1,   1, 8, 11, 'h99, 'h43, 1));
    vq.push_back(v(0, 0, 0, 0,  0, 0, 0,     0, 0, 0,     0, 0, 0,    1,   1, 9, 12, 'h50, 'h51, 0));
    vq.push_back(v(0, 0, 0, 0,  0, 0, 0,     0, 0, 0,     0, 0, 0,    1,   0, 0, 0,  0,    0,    0));
    // three entries resident with a held output, then reset mid-flight
    vq.push_back(v(0, 1, 10, 1, 1, 0, 'h60,  1, 0, 'h61,  0, 0, 0,    0,   0, 0, 0,  0,    0,    1));
    vq.push_back(v(0, 1, 11, 2, 1, 0, 'h62,  1, 0, 'h63,  0, 0, 0,    0,   1, 10, 1, 'h60, 'h61, 1));
    vq.push_back(v(0, 1, 12, 5, 1, 0, 'h64,  1, 0, 'h65,  0, 0, 0,    0,   1, 10, 1, 'h60, 'h61, 2));
    vq.push_back(v(0, 1, 13, 6, 1, 0, 'h66,  1, 0, 'h67,  0, 0, 0,    0,   1, 10, 1, 'h60, 'h61, 3));
    vq.push_back(v(1, 0, 0, 0,  0, 0, 0,     0, 0, 0,     0, 0, 0,    0,   0, 0, 0,  0,    0,    0));
    vq.push_back(v(0, 0, 0, 0,  0, 0, 0,     0, 0, 0,     0, 0, 0,    1,   0, 0, 0,  0,    0,    0));
    vq.push_back(v(0, 1, 14, 13, 1, 0, 'h70, 1, 0, 'h71,  0, 0, 0,    1,   0, 0, 0,  0,    0,    1));
    vq.push_back(v(0, 0, 0, 0,  0, 0, 0,     0, 0, 0,     0, 0, 0,    1,   1, 14, 13, 'h70, 'h71, 0));
    vq.push_back(v(0, 0, 0, 0,  0, 0, 0,     0, 0, 0,     0, 0, 0,    1,   0, 0, 0,  0,    0,    0));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
      check(i, vq[i]);
    end

    // Back-to-back ready dispatches must issue on consecutive cycles, in order.
    first_c = -1;
    last_c  = -1;
    for (int c = 0; c < 10; c++) begin
      drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      if (c < 3) begin
        dis_vld = 1'b1;  dis_op = OP_W'(c + 1);  dis_dst_tag = TAG_W'(c + 1);
        dis_s0_rdy = 1'b1;  dis_s0_data = DATA_W'(c);
        dis_s1_rdy = 1'b1;  dis_s1_data = DATA_W'(c + 16);
        exp_q.push_back(TAG_W'(c + 1));
      end
      @(posedge clk);
      #1;
      if (iss_vld_r) begin
        n_vec++;
        if (first_c < 0) first_c = c;
        last_c = c;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL thru unexpected issue dst %h at cycle %0d", iss_dst_tag_r, c);
        end else begin
          logic [TAG_W-1:0] e;
          e = exp_q.pop_front();
          if (iss_dst_tag_r !== e) begin
            n_bad++; $display("FAIL thru dst got %h want %h", iss_dst_tag_r, e);
          end
        end
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL thru pending issues got %0d want 0", exp_q.size());
    end
    n_vec++;
    if (first_c != 1 || last_c - first_c != 2) begin
      n_bad++; $display("FAIL thru issue window got cycles %0d..%0d want 1..3", first_c, last_c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tomasulo_rs_aged.md
TOMASULO_RS_AGED -- requirements
Module: tomasulo_rs_aged

Interface
REQ-001 Parameter N, default 4, number of reservation-station entries (N >= 2).
REQ-002 Parameter TAG_W, default 4, producer/destination tag width.
REQ-003 Parameter DATA_W, default 32, operand data width.
REQ-004 Parameter OP_W, default 4, opcode width.
REQ-005 Ports, clock and reset first; reset rst, synchronous, active-high; clock clk:
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 dis_vld  in  1  dispatch request
 dis_rdy  out  1  dispatch accepted this cycle when high with dis_vld
 dis_op  in  OP_W  opcode
 dis_dst_tag  in  TAG_W  destination tag
 dis_sK_rdy  in  1  source K (K=0,1) value present
 dis_sK_tag  in  TAG_W  source K producer tag
 dis_sK_data  in  DATA_W  source K value
 cdb_vld  in  1  common data bus broadcast valid
 cdb_tag  in  TAG_W  broadcast tag
 cdb_data  in  DATA_W  broadcast value
 iss_vld_r  out  1  issue output valid (registered)
 iss_rdy  in  1  functional unit accepts issue
 iss_op_r  out  OP_W  issued opcode
 iss_dst_tag_r  out  TAG_W  issued destination tag
 iss_s0_r, iss_s1_r  out  DATA_W  issued operands
 full_r  out  1  all entries occupied
 empty_r  out  1  no entries occupied
 occ_r  out  $clog2(N+1)  occupied-entry count

Function
REQ-006 Each entry SHALL hold valid, op, dst_tag, and per source {rdy, tag, data}.
REQ-007 dis_rdy SHALL equal !full_r; no same-cycle free-to-dispatch bypass.
REQ-008 Accepted dispatch SHALL write the lowest-index free entry at the next edge.
REQ-009 CDB snoop: each valid entry source with !rdy and tag == cdb_tag under cdb_vld SHALL capture cdb_data and set rdy at the next edge.
REQ-010 Dispatch-cycle bypass: a dispatched source with !dis_sK_rdy and tag matching a same-cycle CDB broadcast SHALL be written ready with cdb_data.
REQ-011 An entry SHALL be selectable only when valid and both sources rdy as registered; no same-cycle wake-and-select.
REQ-012 Selection SHALL pick the oldest ready entry by dispatch order, independent of index.
REQ-013 Output stage SHALL load when !iss_vld_r or iss_rdy; on load the selected entry SHALL be freed at the same edge.
REQ-014 When iss_vld_r && !iss_rdy, all iss_*_r outputs SHALL hold stable and no entry SHALL be freed.
REQ-015 Latency: dispatch with both sources ready at edge t -> entry valid after t -> iss_vld_r high after edge t+1 (2 cycles), given an empty output stage.
REQ-016 Throughput: one issue per cycle sustained while iss_rdy high and ready entries exist.
REQ-017 occ_r SHALL update by +1 dispatch, -1 issue-load, net 0 when both; full_r = (occ==N), empty_r = (occ==0), all registered.
REQ-018 Dispatch and issue-load in the same cycle when full_r is high SHALL NOT occur (dis_rdy low); freed slot is available the following cycle.
REQ-019 CDB broadcasts matching no entry SHALL have no effect; one broadcast MAY wake multiple sources/entries.

Reset
REQ-020 On rst: all entry valid bits 0, age state cleared, iss_vld_r 0, occ_r 0, full_r 0, empty_r 1; data fields SHALL NOT be reset.
REQ-021 rst asserted mid-operation SHALL discard all entries and any held issue without emitting further iss_vld_r.

Structure
REQ-022 Entry, dispatch and issue struct typedefs and the CDB type SHALL live in tomasulo_pkg, parameter-sized.
REQ-023 Age ordering SHALL be a sub-module tomasulo_age_matrix (N x N relative-age bits; set on allocate, cleared on free, oldest-ready one-hot output).

Verification (N=4)
REQ-024 Dispatch tag 3, sources ready (0x10, 0x20), iss_rdy=1 -> iss_vld_r high 2 cycles later with operands 0x10/0x20, dst 3.
REQ-025 Dispatch A (s0 waits tag 5), then B ready; CDB tag 5 data 0xAA -> B issues first, A issues next with s0=0xAA.
REQ-026 Dispatch 4 waiting entries -> full_r=1, dis_rdy=0, occ_r=4; 5th dis_vld held until one entry issues, then accepted next cycle.
REQ-027 Dispatch with s1 tag 7 not ready while cdb_vld tag 7 data 0x55 same cycle -> entry issues with s1=0x55, no further wait.
REQ-028 iss_rdy=0 for 5 cycles with iss_vld_r high -> outputs constant, occ_r unchanged; iss_rdy=1 -> next oldest entry follows one cycle later.
REQ-029 rst asserted with 3 entries valid and output held -> next cycle iss_vld_r=0, empty_r=1, occ_r=0.
